// File: rtl/stopwatch_tx_report.sv
// Stopwatch status reporter: snapshots the time and run state on request and
// streams it as an ASCII frame ("R 01:02:03.45\r\n") into the UART TX FIFO.
module stopwatch_tx_report #(
  parameter int SEND_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       run_stop,
  input  logic [4:0] w_hour,
  input  logic [5:0] w_min,
  input  logic [5:0] w_sec,
  input  logic [6:0] w_msec,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_data,
  output logic       busy
);

  localparam int FRAME_LEN = (SEND_STATUS != 0) ? 15 : 13;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic       pending_reg, pending_next;
  logic       capture;

  logic       snap_run_reg;
  logic [4:0] snap_hour_reg;
  logic [5:0] snap_min_reg;
  logic [5:0] snap_sec_reg;
  logic [6:0] snap_msec_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= 4'd0;
      pending_reg   <= 1'b0;
      snap_run_reg  <= 1'b0;
      snap_hour_reg <= 5'd0;
      snap_min_reg  <= 6'd0;
      snap_sec_reg  <= 6'd0;
      snap_msec_reg <= 7'd0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pending_reg <= pending_next;
      // Saturate once at capture so the formatter only ever sees legal values
      if (capture) begin
        snap_run_reg  <= run_stop;
        snap_hour_reg <= (w_hour > 5'd23) ? 5'd23 : w_hour;
        snap_min_reg  <= (w_min > 6'd59) ? 6'd59 : w_min;
        snap_sec_reg  <= (w_sec > 6'd59) ? 6'd59 : w_sec;
        snap_msec_reg <= (w_msec > 7'd99) ? 7'd99 : w_msec;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pending_next = pending_reg;
    capture      = 1'b0;
    tx_push      = 1'b0;
    busy         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req || pending_reg) begin
          capture      = 1'b1;
          idx_next     = 4'd0;
          pending_next = 1'b0;
          state_next   = SEND;
        end
      end
      SEND: begin
        busy    = 1'b1;
        tx_push = ~tx_full;
        if (req) pending_next = 1'b1;
        if (tx_push) begin
          idx_next = idx_reg + 4'd1;
          if (idx_reg == LAST_IDX) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) tx_push = 1'b0;
  end

  // Field order: hour, minute, second, centisecond
  logic [6:0] field   [4];
  logic [7:0] tens_ch [4];
  logic [7:0] ones_ch [4];

  assign field[0] = {2'b00, snap_hour_reg};
  assign field[1] = {1'b0, snap_min_reg};
  assign field[2] = {1'b0, snap_sec_reg};
  assign field[3] = snap_msec_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign tens_ch[gi] = 8'h30 + {1'b0, field[gi] / 7'd10};
      assign ones_ch[gi] = 8'h30 + {1'b0, field[gi] % 7'd10};
    end
  endgenerate

  // Without the status prefix the index is shifted onto the same byte map
  logic [3:0] pos;
  logic [7:0] frame_byte;
  assign pos = (SEND_STATUS != 0) ? idx_reg : idx_reg + 4'd2;

  always_comb begin
    frame_byte = 8'h00;
    case (pos)
      4'd0:    frame_byte = snap_run_reg ? 8'h52 : 8'h53;
      4'd1:    frame_byte = 8'h20;
      4'd2:    frame_byte = tens_ch[0];
      4'd3:    frame_byte = ones_ch[0];
      4'd4:    frame_byte = 8'h3A;
      4'd5:    frame_byte = tens_ch[1];
      4'd6:    frame_byte = ones_ch[1];
      4'd7:    frame_byte = 8'h3A;
      4'd8:    frame_byte = tens_ch[2];
      4'd9:    frame_byte = ones_ch[2];
      4'd10:   frame_byte = 8'h2E;
      4'd11:   frame_byte = tens_ch[3];
      4'd12:   frame_byte = ones_ch[3];
      4'd13:   frame_byte = 8'h0D;
      4'd14:   frame_byte = 8'h0A;
      default: frame_byte = 8'h00;
    endcase
  end

  assign tx_data = (state_reg == SEND) ? frame_byte : 8'h00;

endmodule

// File: tb/tb_stopwatch_tx_report.sv
// Directed bench for stopwatch_tx_report: one instance with the status prefix
// and one without, sharing clock, reset, time inputs and tx_full.
module tb_stopwatch_tx_report;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       req0 = 1'b0;
  logic       run_stop = 1'b0;
  logic [4:0] w_hour = '0;
  logic [5:0] w_min = '0;
  logic [5:0] w_sec = '0;
  logic [6:0] w_msec = '0;
  logic       tx_full = 1'b0;
  logic       tx_push, tx_push0;
  logic [7:0] tx_data, tx_data0;
  logic       busy, busy0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int busy_cnt0 = 0;
  logic [7:0] q[$];
  logic [7:0] q0[$];
  int         qc[$];

  stopwatch_tx_report #(.SEND_STATUS(1)) dut (
    .clk(clk), .rst(rst), .req(req), .run_stop(run_stop),
    .w_hour(w_hour), .w_min(w_min), .w_sec(w_sec), .w_msec(w_msec),
    .tx_full(tx_full), .tx_push(tx_push), .tx_data(tx_data), .busy(busy)
  );

  stopwatch_tx_report #(.SEND_STATUS(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .run_stop(run_stop),
    .w_hour(w_hour), .w_min(w_min), .w_sec(w_sec), .w_msec(w_msec),
    .tx_full(tx_full), .tx_push(tx_push0), .tx_data(tx_data0), .busy(busy0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_push) begin
      q.push_back(tx_data);
      qc.push_back(cyc);
    end
    if (tx_push0) q0.push_back(tx_data0);
    if (busy) busy_cnt++;
    if (busy0) busy_cnt0++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int first_diff(input logic [7:0] got[$], input string exp);
    for (int i = 0; i < exp.len(); i++) begin
      if (i >= got.size()) return i;
      if (got[i] !== exp[i]) return i;
    end
    if (got.size() != exp.len()) return exp.len();
    return -1;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] got[$], input string exp);
    $display("frame %s: %0d bytes pushed, %0d expected", tag, got.size(), exp.len());
    check(tag, first_diff(got, exp), -1);
  endtask

  task automatic clear_capture();
    q.delete();
    qc.delete();
    q0.delete();
    busy_cnt = 0;
    busy_cnt0 = 0;
  endtask

  task automatic wait_bytes(input bit sel0, input int n, input int budget, input string tag);
    int k = 0;
    while (((sel0 ? q0.size() : q.size()) < n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, ((sel0 ? q0.size() : q.size()) >= n), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, 0);
  endtask

  // Returns #1 after the edge that samples req, i.e. during byte 0
  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  task automatic set_time(input logic r, input logic [4:0] h, input logic [5:0] m,
                          input logic [5:0] s, input logic [6:0] c);
    run_stop = r; w_hour = h; w_min = m; w_sec = s; w_msec = c;
  endtask

  string crlf = "\015\012";

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_push", tx_push, 0);
    check("rst_busy", busy, 0);
    check("rst_data", tx_data, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

    // Basic frame and first-byte latency
    set_time(1'b1, 5'd1, 6'd2, 6'd3, 7'd45);
    clear_capture();
    @(posedge clk); #1 req = 1'b1;
    @(negedge clk);
    check("lat_idle_push", tx_push, 0);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    check("lat_first_push", tx_push, 1);
    check("lat_first_data", tx_data, 8'h52);
    wait_bytes(1'b0, 15, 100, "basic_timeout");
    wait_idle(20, "basic_idle");
    check_frame("basic", q, {"R 01:02:03.45", crlf});
    check("basic_busy_cycles", busy_cnt, 15);
    check("basic_back_to_back", qc[14] - qc[0], 14);

    // Backpressure stall at byte 4
    set_time(1'b0, 5'd12, 6'd34, 6'd56, 7'd78);
    clear_capture();
    pulse_req();
    repeat (4) @(posedge clk);
    #1 tx_full = 1'b1;
    @(negedge clk);
    check("stall_push", tx_push, 0);
    check("stall_busy", busy, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stall_count", q.size(), 4);
    @(posedge clk); #1 tx_full = 1'b0;
    wait_bytes(1'b0, 15, 100, "stall_timeout");
    wait_idle(20, "stall_idle");
    check_frame("stall", q, {"S 12:34:56.78", crlf});

    // Snapshot isolation
    set_time(1'b1, 5'd0, 6'd0, 6'd59, 7'd99);
    clear_capture();
    pulse_req();
    set_time(1'b1, 5'd0, 6'd1, 6'd0, 7'd0);
    wait_bytes(1'b0, 15, 100, "snap_timeout");
    wait_idle(20, "snap_idle");
    check_frame("snapshot", q, {"R 00:00:59.99", crlf});

    // Requests at byte 7 and byte 9: one pending frame, inputs taken at its start
    set_time(1'b1, 5'd10, 6'd20, 6'd30, 7'd40);
    clear_capture();
    pulse_req();
    repeat (7) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 req = 1'b1;
    set_time(1'b0, 5'd11, 6'd22, 6'd33, 7'd44);
    @(posedge clk); #1 req = 1'b0;
    wait_bytes(1'b0, 30, 200, "pend_timeout");
    wait_idle(20, "pend_idle");
    check_frame("pend_first", q[0:14], {"R 10:20:30.40", crlf});
    check_frame("pend_second", q[15:29], {"S 11:22:33.44", crlf});
    check("pend_gap", qc[15] - qc[14], 2);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("pend_no_third", q.size(), 30);

    // Reset at byte 6 with a request pending
    set_time(1'b1, 5'd5, 6'd6, 6'd7, 7'd8);
    clear_capture();
    pulse_req();
    repeat (3) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_push", tx_push, 0);
    check("rst_mid_count", q.size(), 6);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_no_pending", q.size(), 6);
    clear_capture();
    pulse_req();
    wait_bytes(1'b0, 15, 100, "rst_new_timeout");
    wait_idle(20, "rst_new_idle");
    check_frame("after_reset", q, {"R 05:06:07.08", crlf});

    // Saturation of every field with the status prefix
    set_time(1'b0, 5'd24, 6'd63, 6'd60, 7'd127);
    clear_capture();
    pulse_req();
    wait_bytes(1'b0, 15, 100, "sat_timeout");
    wait_idle(20, "sat_idle");
    check_frame("saturate", q, {"S 23:59:59.99", crlf});

    // No status prefix: 13-byte frame with saturation
    set_time(1'b1, 5'd31, 6'd0, 6'd0, 7'd120);
    clear_capture();
    @(posedge clk); #1 req0 = 1'b1;
    @(posedge clk); #1 req0 = 1'b0;
    wait_bytes(1'b1, 13, 100, "nostat_timeout");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("nostat_idle", busy0, 0);
    check_frame("nostatus", q0, {"23:00:00.99", crlf});
    check("nostat_busy_cycles", busy_cnt0, 13);
    check("nostat_other_quiet", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
